// File: rtl/uart_tx_cfg_pkg.sv
// Shared types and helpers for the configurable UART transmitter.
package uart_tx_cfg_pkg;

  // Frame FSM states; encoding matches the configurable RX.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Parity-mode codes; 2'b11 is reserved and behaves as none.
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Parity bit from the reduction XOR of the data word.
  function automatic logic parity_bit(input logic [1:0] mode, input logic xr);
    return (mode == PAR_ODD) ? ~xr : xr;
  endfunction

  // Parity is only sent for the even and odd codes.
  function automatic logic parity_on(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, DBIT data bits LSB first,
// optional even/odd parity, one or two stop bits. Bit timing comes from an
// external s_tick, SB_TICK ticks per bit.
//
// Handshake: a word is accepted on a rising clk edge where tx_valid and
// tx_ready are both 1. tx_ready is high only in IDLE and never during reset;
// tx_valid may be held high to send back-to-back frames.
module uart_tx_cfg
  import uart_tx_cfg_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            tx_valid,
  output logic            tx_ready,
  input  logic [DBIT-1:0] din,
  input  logic [1:0]      parity_mode,
  input  logic            stop2,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick,
  output logic [2:0]      dbg_state
);

  // Tick counter is wide enough to count two stop bits in one run.
  localparam int TW = $clog2(2 * SB_TICK);
  localparam int BW = $clog2(DBIT);
  localparam logic [TW-1:0] TICK_LAST  = TW'(SB_TICK - 1);
  localparam logic [TW-1:0] STOP2_LAST = TW'(2 * SB_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(DBIT - 1);

  state_t            state_q, state_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DBIT-1:0]   sh_q, sh_d;
  logic              par_q, par_d;
  logic              par_en_q, par_en_d;
  logic              stop2_q, stop2_d;
  logic              tx_q, tx_d;
  logic [TW-1:0]     stop_last;

  // State and datapath registers; reset aborts any frame and idles the line.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
      stop2_q  <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      par_q    <= par_d;
      par_en_q <= par_en_d;
      stop2_q  <= stop2_d;
      tx_q     <= tx_d;
    end
  end

  assign stop_last = stop2_q ? STOP2_LAST : TICK_LAST;

  // Next-state logic; tx_d is the line value for the cycle after this edge.
  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    bit_d        = bit_q;
    sh_d         = sh_q;
    par_d        = par_q;
    par_en_d     = par_en_q;
    stop2_d      = stop2_q;
    tx_d         = tx_q;
    tx_ready     = 1'b0;
    tx_done_tick = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d     = 1'b1;
        tx_ready = !reset;
        if (tx_valid) begin
          state_d  = START;
          tick_d   = '0;
          bit_d    = '0;
          sh_d     = din;
          par_d    = parity_bit(parity_mode, ^din);
          par_en_d = parity_on(parity_mode);
          stop2_d  = stop2;
          tx_d     = 1'b0;
        end
      end
      START: begin
        if (s_tick) begin
          if (tick_q == TICK_LAST) begin
            state_d = DATA;
            tick_d  = '0;
            tx_d    = sh_q[0];
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (bit_q == BIT_LAST) begin
              if (par_en_q) begin
                state_d = PARITY;
                tx_d    = par_q;
              end else begin
                state_d = STOP;
                tx_d    = 1'b1;
              end
            end else begin
              sh_d  = sh_q >> 1;
              bit_d = bit_q + 1'b1;
              tx_d  = sh_q[1];
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (tick_q == TICK_LAST) begin
            state_d = STOP;
            tick_d  = '0;
            tx_d    = 1'b1;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (tick_q == stop_last) begin
            state_d      = IDLE;
            tick_d       = '0;
            tx_done_tick = !reset;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign tx        = tx_q;
  assign tx_busy   = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule
